// File: rtl/i2c_txn_arbiter.sv
// Round-robin sharing of one I2C byte engine between two requesters; grant 1 cycle after req in IDLE.
// Command held in ISSUE until cmd_ready_i; BUSY watchdog forces abort; fixed bus-free gap after each response.
module i2c_txn_arbiter #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd100000,
    parameter logic [7:0]  GAP_CYC     = 8'd8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  req_rw_i,
    input  logic [13:0] req_dev_i,
    input  logic [15:0] req_reg_i,
    input  logic [15:0] req_wdata_i,
    input  logic [1:0]  req_rlen_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rsp_valid_o,
    output logic [1:0]  rsp_err_o,
    output logic [15:0] rsp_data_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        cmd_rw_o,
    output logic [6:0]  cmd_dev_o,
    output logic [7:0]  cmd_reg_o,
    output logic [7:0]  cmd_wdata_o,
    output logic        cmd_rlen_o,
    input  logic        eng_done_i,
    input  logic        eng_nack_i,
    input  logic [15:0] eng_rdata_i,
    output logic        eng_abort_o,
    output logic        busy_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_BUSY  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        win_q, win_d;
    logic        last_q, last_d;
    logic [23:0] wdog_q, wdog_d;
    logic [7:0]  gap_q, gap_d;
    logic        cmd_rw_q, cmd_rw_d;
    logic [6:0]  cmd_dev_q, cmd_dev_d;
    logic [7:0]  cmd_reg_q, cmd_reg_d;
    logic [7:0]  cmd_wdata_q, cmd_wdata_d;
    logic        cmd_rlen_q, cmd_rlen_d;
    logic [1:0]  rsp_err_q, rsp_err_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        pick;
    logic        timeout;
    logic [1:0]  win_oh;

    // On a tie the requester not served last wins; otherwise whoever is asking.
    assign pick    = (req_i == 2'b11) ? ~last_q : req_i[1];
    assign timeout = (wdog_q == TIMEOUT_CYC - 24'd1);
    assign win_oh  = win_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        last_d      = last_q;
        wdog_d      = wdog_q;
        gap_d       = gap_q;
        cmd_rw_d    = cmd_rw_q;
        cmd_dev_d   = cmd_dev_q;
        cmd_reg_d   = cmd_reg_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_rlen_d  = cmd_rlen_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    win_d       = pick;
                    cmd_rw_d    = req_rw_i[pick];
                    cmd_dev_d   = pick ? req_dev_i[13:7]   : req_dev_i[6:0];
                    cmd_reg_d   = pick ? req_reg_i[15:8]   : req_reg_i[7:0];
                    cmd_wdata_d = pick ? req_wdata_i[15:8] : req_wdata_i[7:0];
                    cmd_rlen_d  = req_rlen_i[pick];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready_i) begin
                    wdog_d  = 24'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                wdog_d = wdog_q + 24'd1;
                if (eng_done_i) begin
                    rsp_err_d = eng_nack_i ? 2'b01 : 2'b00;
                    if (eng_nack_i || !cmd_rw_q)
                        rsp_data_d = 16'h0000;
                    else
                        rsp_data_d = cmd_rlen_q ? eng_rdata_i : {8'h00, eng_rdata_i[7:0]};
                    state_d = S_RESP;
                end else if (timeout) begin
                    rsp_err_d  = 2'b10;
                    rsp_data_d = 16'h0000;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                last_d  = win_q;
                gap_d   = 8'd0;
                state_d = (GAP_CYC == 8'd0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                gap_d = gap_q + 8'd1;
                if (gap_q == GAP_CYC - 8'd1)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            win_q       <= 1'b0;
            last_q      <= 1'b1;
            wdog_q      <= 24'd0;
            gap_q       <= 8'd0;
            cmd_rw_q    <= 1'b0;
            cmd_dev_q   <= 7'd0;
            cmd_reg_q   <= 8'd0;
            cmd_wdata_q <= 8'd0;
            cmd_rlen_q  <= 1'b0;
            rsp_err_q   <= 2'b00;
            rsp_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            last_q      <= last_d;
            wdog_q      <= wdog_d;
            gap_q       <= gap_d;
            cmd_rw_q    <= cmd_rw_d;
            cmd_dev_q   <= cmd_dev_d;
            cmd_reg_q   <= cmd_reg_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_rlen_q  <= cmd_rlen_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign gnt_o       = (state_q == S_ISSUE || state_q == S_BUSY || state_q == S_RESP) ? win_oh : 2'b00;
    assign rsp_valid_o = (state_q == S_RESP) ? win_oh : 2'b00;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_data_o  = rsp_data_q;
    assign cmd_valid_o = (state_q == S_ISSUE);
    assign cmd_rw_o    = cmd_rw_q;
    assign cmd_dev_o   = cmd_dev_q;
    assign cmd_reg_o   = cmd_reg_q;
    assign cmd_wdata_o = cmd_wdata_q;
    assign cmd_rlen_o  = cmd_rlen_q;
    // A completion landing on the final watchdog cycle takes priority over the abort.
    assign eng_abort_o = (state_q == S_BUSY) && !eng_done_i && timeout;
    assign busy_o      = (state_q != S_IDLE);
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: table of transactions with hand-derived responses,
// plus sequences for tie round-robin, reset in BUSY and request drop after grant.
module tb_i2c_txn_arbiter;
    localparam int TMO = 100;
    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0, req_rw = '0, req_rlen = '0;
    logic [13:0] req_dev = '0;
    logic [15:0] req_reg = '0, req_wdata = '0;
    logic [1:0]  gnt, rsp_valid, rsp_err;
    logic [15:0] rsp_data;
    logic        cmd_valid, cmd_rw, cmd_rlen, eng_abort, busy;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg, cmd_wdata;
    logic        cmd_ready = 1'b0, eng_done = 1'b0, eng_nack = 1'b0;
    logic [15:0] eng_rdata = '0;

    i2c_txn_arbiter #(.TIMEOUT_CYC(24'd100), .GAP_CYC(8'd8)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_rw_i(req_rw), .req_dev_i(req_dev),
        .req_reg_i(req_reg), .req_wdata_i(req_wdata), .req_rlen_i(req_rlen),
        .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_data_o(rsp_data),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_rw_o(cmd_rw),
        .cmd_dev_o(cmd_dev), .cmd_reg_o(cmd_reg), .cmd_wdata_o(cmd_wdata), .cmd_rlen_o(cmd_rlen),
        .eng_done_i(eng_done), .eng_nack_i(eng_nack), .eng_rdata_i(eng_rdata),
        .eng_abort_o(eng_abort), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        who;
        logic        rw;
        logic [6:0]  dev;
        logic [7:0]  rg;
        logic [7:0]  wd;
        logic        rlen;
        int          rdy_dly;
        int          done_k;     // BUSY cycle carrying eng_done, 0 = never
        logic        nack;
        logic [15:0] rdata;
        logic        drop;
        logic [1:0]  exp_err;
        logic [15:0] exp_data;
        int          exp_abort_k;
    } vec_t;

    typedef struct {
        logic [1:0]  vld;
        logic [1:0]  err;
        logic [15:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    int   rsp_pulses = 0, exp_pulses = 0;

    always @(negedge clk) begin
        #1;
        if (rsp_valid != 2'b00) rsp_pulses++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_req(input vec_t v);
        int w;
        w = int'(v.who);
        req_rw[w]          = v.rw;
        req_rlen[w]        = v.rlen;
        req_dev[w*7 +: 7]  = v.dev;
        req_reg[w*8 +: 8]  = v.rg;
        req_wdata[w*8 +: 8] = v.wd;
        req[w]             = 1'b1;
    endtask

    task automatic run_txn(input vec_t v, output int waited);
        bit   got;
        int   abort_k, rsp_k, exp_rsp_k;
        logic [1:0] oh;
        rsp_t r;
        got = 0; waited = 0; abort_k = 0; rsp_k = 0;
        oh = v.who ? 2'b10 : 2'b01;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk); #1;
            waited = i + 1;
            if (cmd_valid) got = 1;
        end
        check("grant_seen", 32'(got), 32'd1);
        if (!got) return;
        check("gnt", 32'(gnt), 32'(oh));
        check("cmd_dev", 32'(cmd_dev), 32'(v.dev));
        check("cmd_reg", 32'(cmd_reg), 32'(v.rg));
        check("cmd_rw", 32'(cmd_rw), 32'(v.rw));
        if (v.rw) check("cmd_rlen", 32'(cmd_rlen), 32'(v.rlen));
        else      check("cmd_wdata", 32'(cmd_wdata), 32'(v.wd));
        sb.push_back('{oh, v.exp_err, v.exp_data});
        exp_pulses++;
        if (v.rdy_dly > 0) begin
            repeat (v.rdy_dly) @(negedge clk);
            #1;
            check("issue_hold", 32'(cmd_valid), 32'd1);
        end
        cmd_ready = 1'b1;
        for (int k = 1; k <= 200 && rsp_k == 0; k++) begin
            @(negedge clk);
            cmd_ready = 1'b0;
            eng_done  = (k == v.done_k);
            eng_nack  = v.nack;
            eng_rdata = v.rdata;
            if (v.drop && k == 2) req[int'(v.who)] = 1'b0;
            #1;
            if (eng_abort && abort_k == 0) abort_k = k;
            if (rsp_valid != 2'b00) rsp_k = k;
        end
        eng_done = 1'b0;
        check("rsp_seen", 32'(rsp_k != 0), 32'd1);
        if (rsp_k == 0) return;
        exp_rsp_k = (v.exp_abort_k != 0) ? v.exp_abort_k + 1 : v.done_k + 1;
        check("rsp_latency", 32'(rsp_k), 32'(exp_rsp_k));
        check("abort_cycle", 32'(abort_k), 32'(v.exp_abort_k));
        r = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(r.vld));
        check("rsp_err", 32'(rsp_err), 32'(r.err));
        check("rsp_data", 32'(rsp_data), 32'(r.data));
    endtask

    initial begin
        vec_t tie[4];
        vec_t tbl[5];
        vec_t v;
        int   w;

        tie[0] = '{1'b0, 1'b1, 7'h38, 8'h44, 8'h00, 1'b1, 0, 4, 1'b0, 16'hABCD, 1'b0, 2'b00, 16'hABCD, 0};
        tie[1] = '{1'b1, 1'b0, 7'h1D, 8'h41, 8'hC6, 1'b0, 0, 4, 1'b0, 16'h9999, 1'b0, 2'b00, 16'h0000, 0};
        tie[2] = '{1'b0, 1'b1, 7'h38, 8'h44, 8'h00, 1'b1, 0, 4, 1'b0, 16'h0055, 1'b0, 2'b00, 16'h0055, 0};
        tie[3] = '{1'b1, 1'b0, 7'h1D, 8'h41, 8'hC6, 1'b0, 0, 4, 1'b1, 16'h9999, 1'b0, 2'b01, 16'h0000, 0};

        tbl[0] = '{1'b1, 1'b0, 7'h1D, 8'h41, 8'hC6, 1'b0, 3, 5,   1'b1, 16'h1234, 1'b0, 2'b01, 16'h0000, 0};
        tbl[1] = '{1'b0, 1'b1, 7'h38, 8'h50, 8'h00, 1'b0, 0, 0,   1'b0, 16'h0000, 1'b0, 2'b10, 16'h0000, 100};
        tbl[2] = '{1'b1, 1'b1, 7'h2A, 8'h10, 8'h00, 1'b0, 0, 100, 1'b0, 16'hBEEF, 1'b0, 2'b00, 16'h00EF, 0};
        tbl[3] = '{1'b0, 1'b0, 7'h38, 8'h41, 8'h5A, 1'b0, 0, 3,   1'b0, 16'h7777, 1'b0, 2'b00, 16'h0000, 0};
        tbl[4] = '{1'b0, 1'b1, 7'h38, 8'h44, 8'h00, 1'b1, 0, 50,  1'b0, 16'h0123, 1'b0, 2'b00, 16'h0123, 0};

        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
        rst = 1'b0;

        // Both requesters held: service must alternate starting with requester 0.
        set_req(tie[0]);
        set_req(tie[1]);
        for (int i = 0; i < 4; i++) begin
            run_txn(tie[i], w);
            check(i == 0 ? "grant_latency" : "gap_len", 32'(w), i == 0 ? 32'd1 : 32'(GAP + 2));
        end
        req = 2'b00;

        foreach (tbl[i]) begin
            set_req(tbl[i]);
            run_txn(tbl[i], w);
            req = 2'b00;
        end

        // Reset in the middle of BUSY: transaction vanishes and arbitration restarts.
        v = '{1'b0, 1'b1, 7'h38, 8'h44, 8'h00, 1'b1, 0, 2, 1'b0, 16'h0AA0, 1'b0, 2'b00, 16'h0AA0, 0};
        set_req(v);
        w = 0;
        for (int i = 0; i < 40 && w == 0; i++) begin
            @(negedge clk); #1;
            if (cmd_valid) w = 1;
        end
        check("rst_case_grant", 32'(w), 32'd1);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_outs", 32'({rsp_valid, rsp_err, cmd_valid, eng_abort, cmd_dev}), 32'd0);
        check("midrst_data", 32'(rsp_data), 32'd0);
        rst = 1'b0;
        set_req('{1'b1, 1'b0, 7'h1D, 8'h41, 8'hC6, 1'b0, 0, 0, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 0});
        run_txn(v, w);
        check("post_rst_latency", 32'(w), 32'd1);
        req = 2'b00;

        // Request dropped after grant still completes; eng_done during GAP is ignored.
        v = '{1'b0, 1'b1, 7'h38, 8'h44, 8'h00, 1'b0, 0, 6, 1'b0, 16'h12C3, 1'b1, 2'b00, 16'h00C3, 0};
        set_req(v);
        run_txn(v, w);
        @(negedge clk);
        eng_done = 1'b1; eng_nack = 1'b1; eng_rdata = 16'hFFFF;
        @(negedge clk);
        eng_done = 1'b0; eng_nack = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("gap_done_err", 32'(rsp_err), 32'd0);
        check("gap_done_data", 32'(rsp_data), 32'h00C3);
        check("idle_after_drop", 32'(busy), 32'd0);

        check("rsp_pulse_count", 32'(rsp_pulses), 32'(exp_pulses));
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end
endmodule
